// File: rtl/door_pkg.sv
// door_pkg: shared door FSM states and LED door-panel pattern decode.
package door_pkg;

    typedef enum logic [1:0] {CLOSED, OPENING, OPEN_HOLD, CLOSING} door_state_t;

    localparam int unsigned PAT_MAX = 64;

    // Panel of led_w LEDs with the middle 2*pos bits cleared; bits at or above led_w are 0.
    function automatic logic [PAT_MAX-1:0] door_pattern(input int unsigned led_w, input int unsigned pos);
        logic [PAT_MAX-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < PAT_MAX; i++)
            p[i] = (i < led_w) && !((i + pos >= led_w / 2) && (i < led_w / 2 + pos));
        return p;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: free-running 0..DIV-1 counter; tick is high while the count is DIV-1.
// Ports: clk system clock, rst async active-high reset, tick one-cycle step strobe.
module step_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = cnt_q == CW'(DIV - 1);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/door_ctrl_param.sv
// door_ctrl_param: elevator door controller with LED panel animation, timed hold and reversal.
// Ports: clk, rst (async active-high); open_req/close_req/obstruct level requests;
//        door_led panel pattern; door_closed high in CLOSED; door_opened high in OPEN_HOLD.
module door_ctrl_param
    import door_pkg::*;
#(
    parameter int LED_W      = 8,
    parameter int STEP_DIV   = 100,
    parameter int HOLD_STEPS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             open_req,
    input  logic             close_req,
    input  logic             obstruct,
    output logic [LED_W-1:0] door_led,
    output logic             door_closed,
    output logic             door_opened
);

    localparam int HALF = LED_W / 2;
    localparam int PW   = $clog2(HALF + 1);
    localparam int HW   = $clog2(HOLD_STEPS + 1);

    door_state_t   state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tick;

    step_prescaler #(.DIV(STEP_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        case (state_q)
            CLOSED:    state_d = open_req ? OPENING : CLOSED;
            OPENING:
                if (tick) begin
                    pos_d = pos_q + PW'(1);
                    if (pos_q == PW'(HALF - 1)) begin
                        state_d = OPEN_HOLD;
                        hold_d  = HW'(HOLD_STEPS);
                    end
                end
            OPEN_HOLD:
                if (open_req || obstruct) hold_d = HW'(HOLD_STEPS);
                else if (close_req) state_d = CLOSING;
                else if (tick) begin
                    hold_d = hold_q - HW'(1);
                    if (hold_q == HW'(1)) state_d = CLOSING;
                end
            default:
                // Reversal keeps pos even when a tick lands on the same cycle.
                if (open_req || obstruct) state_d = OPENING;
                else if (tick) begin
                    pos_d = pos_q - PW'(1);
                    if (pos_q == PW'(1)) state_d = CLOSED;
                end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLOSED;
            pos_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
        end
    end

    assign door_led    = LED_W'(door_pattern(LED_W, 32'(pos_q)));
    assign door_closed = state_q == CLOSED;
    assign door_opened = state_q == OPEN_HOLD;

endmodule

// File: tb/tb_door_ctrl_param.sv
// tb_door_ctrl_param: scoreboard bench; expected output-change events are queued with their cycle index.
module tb_door_ctrl_param;

    logic       clk = 0, rst = 1, open_req = 0, close_req = 0, obstruct = 0;
    logic [7:0] door_led;
    logic       door_closed, door_opened;

    door_ctrl_param #(.LED_W(8), .STEP_DIV(4), .HOLD_STEPS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .open_req    (open_req),
        .close_req   (close_req),
        .obstruct    (obstruct),
        .door_led    (door_led),
        .door_closed (door_closed),
        .door_opened (door_opened)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [7:0] led;
        logic       c;
        logic       o;
    } ev_t;

    ev_t        q[$];
    ev_t        ev;
    int         checks = 0, errors = 0, cyc = 0;
    logic [9:0] cur, prev;

    // Cycle index = rising edges since reset release; every output change must match the queue head.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            cyc++;
            cur = {door_led, door_closed, door_opened};
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_change cyc=%0d got led=%h closed=%b opened=%b", cyc, door_led, door_closed, door_opened);
                end else begin
                    ev = q.pop_front();
                    if (cur !== {ev.led, ev.c, ev.o} || cyc != ev.at) begin
                        errors++;
                        $display("FAIL event got led=%h closed=%b opened=%b at cyc %0d, want led=%h closed=%b opened=%b at cyc %0d",
                                 door_led, door_closed, door_opened, cyc, ev.led, ev.c, ev.o, ev.at);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic exp(input int at, input logic [7:0] led, input logic c, input logic o);
        q.push_back('{at, led, c, o});
    endtask

    task automatic exp_open();
        exp(1, 8'hFF, 0, 0);
        exp(4, 8'hE7, 0, 0);
        exp(8, 8'hC3, 0, 0);
        exp(12, 8'h81, 0, 0);
        exp(16, 8'h00, 0, 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1;
        open_req = 0; close_req = 0; obstruct = 0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        cyc = 0;
        prev = {door_led, door_closed, door_opened};
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({door_led, door_closed, door_opened} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got led=%h closed=%b opened=%b want FF 1 0", door_led, door_closed, door_opened);
        end
    endtask

    task automatic test_auto_cycle();
        do_reset();
        exp_open();
        exp(28, 8'h00, 0, 0);
        exp(32, 8'h81, 0, 0);
        exp(36, 8'hC3, 0, 0);
        exp(40, 8'hE7, 0, 0);
        exp(44, 8'hFF, 1, 0);
        open_req = 1; step(1); open_req = 0;
        step(48);
        checks++;
        if (q.size() != 0 || door_led !== 8'hFF || door_closed !== 1'b1) begin
            errors++;
            $display("FAIL auto_cycle_end pending=%0d led=%h closed=%b want 0 FF 1", q.size(), door_led, door_closed);
        end
    endtask

    task automatic test_close_button();
        do_reset();
        exp_open();
        exp(17, 8'h00, 0, 0);
        exp(20, 8'h81, 0, 0);
        exp(24, 8'hC3, 0, 0);
        exp(28, 8'hE7, 0, 0);
        exp(32, 8'hFF, 1, 0);
        open_req = 1; step(1); open_req = 0;
        step(15);
        close_req = 1; step(1); close_req = 0;
        step(19);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL close_button pending=%0d want 0", q.size());
        end
    endtask

    task automatic test_reversal();
        do_reset();
        exp_open();
        exp(28, 8'h00, 0, 0);
        exp(32, 8'h81, 0, 0);
        exp(36, 8'hC3, 0, 0);
        exp(44, 8'h81, 0, 0);
        exp(48, 8'h00, 0, 1);
        exp(60, 8'h00, 0, 0);
        exp(64, 8'h81, 0, 0);
        open_req = 1; step(1); open_req = 0;
        step(38);
        open_req = 1; step(1); open_req = 0;
        step(27);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL reversal pending=%0d want 0", q.size());
        end
    endtask

    task automatic test_obstruction();
        do_reset();
        exp_open();
        exp(108, 8'h00, 0, 0);
        exp(112, 8'h81, 0, 0);
        open_req = 1; step(1); open_req = 0;
        step(15);
        obstruct = 1; step(80); obstruct = 0;
        step(19);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL obstruction pending=%0d want 0", q.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        exp_open();
        exp(52, 8'h00, 0, 0);
        exp(56, 8'h81, 0, 0);
        exp(60, 8'hC3, 0, 0);
        exp(64, 8'hE7, 0, 0);
        exp(68, 8'hFF, 1, 0);
        open_req = 1; step(1); open_req = 0;
        step(15);
        open_req = 1; close_req = 1; step(24); open_req = 0; close_req = 0;
        step(28);
        close_req = 1; step(8); close_req = 0;
        obstruct = 1; step(4); obstruct = 0;
        step(4);
        checks++;
        if (q.size() != 0 || door_led !== 8'hFF || door_closed !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous pending=%0d led=%h closed=%b want 0 FF 1", q.size(), door_led, door_closed);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        exp(1, 8'hFF, 0, 0);
        exp(4, 8'hE7, 0, 0);
        exp(8, 8'hC3, 0, 0);
        open_req = 1; step(1); open_req = 0;
        step(8);
        rst = 1;
        #1;
        checks++;
        if ({door_led, door_closed, door_opened} !== {8'hFF, 1'b1, 1'b0} || q.size() != 0) begin
            errors++;
            $display("FAIL async_reset got led=%h closed=%b opened=%b pending=%0d want FF 1 0 0", door_led, door_closed, door_opened, q.size());
        end
        do_reset();
        exp(1, 8'hFF, 0, 0);
        exp(4, 8'hE7, 0, 0);
        open_req = 1; step(1); open_req = 0;
        step(5);
        checks++;
        if (q.size() != 0 || door_led !== 8'hE7) begin
            errors++;
            $display("FAIL prescaler_restart pending=%0d led=%h want 0 E7", q.size(), door_led);
        end
    endtask

    initial begin
        test_reset();
        test_auto_cycle();
        test_close_button();
        test_reversal();
        test_obstruction();
        test_simultaneous();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
